// File: rtl/juggle_scheduler_if.sv
// rtl/juggle_scheduler_if.sv - control, height handshake and status bundle for juggle_scheduler
interface juggle_scheduler_if #(
  parameter int TIME_W   = 9,
  parameter int HEIGHT_W = 4
);
  logic                start_in;
  logic                stop_in;
  logic [2:0]          num_balls_in;
  logic                beat_in;
  logic                height_valid_in;
  logic [HEIGHT_W-1:0] height_in;
  logic                height_ready_out;
  logic                throw_valid_out;
  logic [2:0]          throw_ball_out;
  logic [2:0]          next_ball_out;
  logic [TIME_W-1:0]   next_time_out;
  logic                busy_out;
  logic                error_out;
  logic [1:0]          error_code_out;

  // Upstream side: pattern source plus run control.
  modport master (
    output start_in, stop_in, num_balls_in, beat_in, height_valid_in, height_in,
    input  height_ready_out, throw_valid_out, throw_ball_out, next_ball_out,
    input  next_time_out, busy_out, error_out, error_code_out
  );

  // Scheduler side.
  modport slave (
    input  start_in, stop_in, num_balls_in, beat_in, height_valid_in, height_in,
    output height_ready_out, throw_valid_out, throw_ball_out, next_ball_out,
    output next_time_out, busy_out, error_out, error_code_out
  );
endinterface

// File: rtl/juggle_scheduler.sv
// rtl/juggle_scheduler.sv - beat-driven throw scheduler with per-ball landing countdowns
module juggle_scheduler #(
  parameter int MAX_BALLS = 7,
  parameter int TIME_W    = 9,
  parameter int HEIGHT_W  = 4
) (
  input logic               clk_in,
  input logic               rst_in,
  juggle_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_WAIT_HEIGHT, S_ERR
  } state_t;

  localparam logic [1:0] ERR_COLLISION = 2'b01;
  localparam logic [1:0] ERR_ZERO      = 2'b10;
  localparam logic [1:0] ERR_OVERRUN   = 2'b11;

  state_t               state;
  logic [TIME_W-1:0]    cnt [MAX_BALLS];
  logic [MAX_BALLS-1:0] active;
  logic [2:0]           num_balls;
  logic [2:0]           cur_ball;

  logic                 min_found;
  logic [2:0]           min_idx;
  logic [TIME_W-1:0]    min_time;
  logic [TIME_W-1:0]    new_time;
  logic                 collide;
  logic                 handshake;

  assign new_time  = TIME_W'(bus.height_in) - TIME_W'(1);
  assign handshake = bus.height_valid_in && bus.height_ready_out;

  // Earliest-landing active ball; strict less-than keeps the lowest index on ties.
  always_comb begin
    min_found = 1'b0;
    min_idx   = '0;
    min_time  = '0;
    for (int i = 0; i < MAX_BALLS; i++) begin
      if (active[i] && (!min_found || cnt[i] < min_time)) begin
        min_found = 1'b1;
        min_idx   = 3'(i);
        min_time  = cnt[i];
      end
    end
  end

  // A new landing beat collides when another airborne ball lands on the same beat.
  always_comb begin
    collide = 1'b0;
    for (int j = 0; j < MAX_BALLS; j++) begin
      if (active[j] && (3'(j) != cur_ball) && (cnt[j] == new_time)) begin
        collide = 1'b1;
      end
    end
  end

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state                <= S_IDLE;
      active               <= '0;
      num_balls            <= '0;
      cur_ball             <= '0;
      for (int i = 0; i < MAX_BALLS; i++) cnt[i] <= '0;
      bus.height_ready_out <= 1'b0;
      bus.throw_valid_out  <= 1'b0;
      bus.throw_ball_out   <= '0;
      bus.next_ball_out    <= '0;
      bus.next_time_out    <= '0;
      bus.busy_out         <= 1'b0;
      bus.error_out        <= 1'b0;
      bus.error_code_out   <= '0;
    end else begin
      bus.throw_valid_out <= 1'b0;
      bus.next_ball_out   <= min_idx;
      bus.next_time_out   <= min_time;
      if (bus.stop_in) begin
        state                <= S_IDLE;
        active               <= '0;
        for (int i = 0; i < MAX_BALLS; i++) cnt[i] <= '0;
        bus.height_ready_out <= 1'b0;
        bus.busy_out         <= 1'b0;
        bus.error_out        <= 1'b0;
        bus.error_code_out   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start_in && bus.num_balls_in != 3'd0) begin
              num_balls    <= bus.num_balls_in;
              bus.busy_out <= 1'b1;
              state        <= S_LOAD;
            end
          end
          S_LOAD: begin
            for (int i = 0; i < MAX_BALLS; i++) begin
              active[i] <= (i < int'(num_balls));
              cnt[i]    <= (i < int'(num_balls)) ? TIME_W'(i) : '0;
            end
            state <= S_RUN;
          end
          S_RUN: begin
            if (bus.beat_in) begin
              if (min_found && min_time == '0) begin
                // The landing ball is caught and held; everyone else moves one beat closer.
                for (int i = 0; i < MAX_BALLS; i++) begin
                  if (active[i] && 3'(i) != min_idx && cnt[i] != '0) cnt[i] <= cnt[i] - 1'b1;
                end
                cur_ball             <= min_idx;
                bus.throw_valid_out  <= 1'b1;
                bus.throw_ball_out   <= min_idx;
                bus.height_ready_out <= 1'b1;
                state                <= S_WAIT_HEIGHT;
              end else begin
                for (int i = 0; i < MAX_BALLS; i++) begin
                  if (active[i] && cnt[i] != '0) cnt[i] <= cnt[i] - 1'b1;
                end
              end
            end
          end
          S_WAIT_HEIGHT: begin
            if (handshake) begin
              bus.height_ready_out <= 1'b0;
              if (bus.height_in == '0) begin
                bus.busy_out       <= 1'b0;
                bus.error_out      <= 1'b1;
                bus.error_code_out <= ERR_ZERO;
                state              <= S_ERR;
              end else begin
                cnt[cur_ball] <= new_time;
                if (collide) begin
                  bus.busy_out       <= 1'b0;
                  bus.error_out      <= 1'b1;
                  bus.error_code_out <= ERR_COLLISION;
                  state              <= S_ERR;
                end else begin
                  state <= S_RUN;
                end
              end
            end else if (bus.beat_in) begin
              // A beat arrived before the next height: the pattern source fell behind.
              bus.height_ready_out <= 1'b0;
              bus.busy_out         <= 1'b0;
              bus.error_out        <= 1'b1;
              bus.error_code_out   <= ERR_OVERRUN;
              state                <= S_ERR;
            end
          end
          S_ERR: begin
            state <= S_ERR;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_juggle_scheduler.sv
// tb/tb_juggle_scheduler.sv - directed self-checking bench for juggle_scheduler
module tb_juggle_scheduler;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  juggle_scheduler_if bus ();

  juggle_scheduler dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic do_start(input logic [2:0] n);
    bus.num_balls_in = n;
    bus.start_in     = 1'b1;
    tick();
    bus.start_in     = 1'b0;
  endtask

  task automatic do_stop();
    bus.stop_in = 1'b1;
    tick();
    bus.stop_in = 1'b0;
  endtask

  task automatic do_beat();
    bus.beat_in = 1'b1;
    tick();
    bus.beat_in = 1'b0;
  endtask

  task automatic give_height(input logic [3:0] h);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 8 && !done; k++) begin
      if (bus.height_ready_out) begin
        bus.height_valid_in = 1'b1;
        bus.height_in       = h;
        tick();
        bus.height_valid_in = 1'b0;
        done = 1'b1;
      end else begin
        tick();
      end
    end
    if (!done) check("height_ready_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_ball;
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    bus.start_in = 0; bus.stop_in = 0; bus.num_balls_in = 0; bus.beat_in = 0;
    bus.height_valid_in = 0; bus.height_in = 0;
    tick(3);
    check("rst_busy", bus.busy_out, 0);
    check("rst_err", bus.error_out, 0);
    check("rst_ready", bus.height_ready_out, 0);
    check("rst_next_time", bus.next_time_out, 0);
    rst = 1'b0;
    tick();

    // Tie/min with four balls
    do_start(3'd4);
    check("load_busy", bus.busy_out, 1);
    tick(2);
    check("tie_next_ball", bus.next_ball_out, 0);
    check("tie_next_time", bus.next_time_out, 0);
    do_beat();
    check("tie_throw_valid", bus.throw_valid_out, 1);
    check("tie_throw_ball", bus.throw_ball_out, 0);
    give_height(4'd4);
    tick();
    check("tie_after_ball", bus.next_ball_out, 1);
    check("tie_after_time", bus.next_time_out, 0);
    do_stop();

    // Cascade: three balls, height 3 every throw
    do_start(3'd3);
    tick(2);
    for (int b = 0; b < 7; b++) begin
      exp_ball = b % 3;
      do_beat();
      check("cascade_throw_valid", bus.throw_valid_out, 1);
      check("cascade_throw_ball", bus.throw_ball_out, exp_ball);
      give_height(4'd3);
      tick();
      check("cascade_time_le2", (bus.next_time_out <= 2), 1);
    end
    check("cascade_no_err", bus.error_out, 0);
    check("cascade_busy", bus.busy_out, 1);
    do_stop();

    // Collision: height 2 lands ball 0 on ball 2's beat
    do_start(3'd3);
    tick(2);
    do_beat();
    give_height(4'd2);
    check("coll_err", bus.error_out, 1);
    check("coll_code", bus.error_code_out, 1);
    check("coll_busy", bus.busy_out, 0);
    do_beat();
    check("coll_beat_ignored", bus.throw_valid_out, 0);
    check("coll_code_held", bus.error_code_out, 1);
    do_stop();
    check("coll_stop_err", bus.error_out, 0);
    check("coll_stop_code", bus.error_code_out, 0);
    tick();
    check("coll_stop_next_time", bus.next_time_out, 0);

    // Zero height
    do_start(3'd1);
    tick(2);
    do_beat();
    check("zero_throw_ball", bus.throw_ball_out, 0);
    give_height(4'd0);
    check("zero_err", bus.error_out, 1);
    check("zero_code", bus.error_code_out, 2);
    do_stop();

    // Height 1 with one ball: throw every beat
    do_start(3'd1);
    tick(2);
    for (int b = 0; b < 3; b++) begin
      do_beat();
      check("h1_throw_valid", bus.throw_valid_out, 1);
      check("h1_throw_ball", bus.throw_ball_out, 0);
      give_height(4'd1);
    end
    check("h1_no_err", bus.error_out, 0);
    do_stop();

    // Overrun: second beat without height
    do_start(3'd2);
    tick(2);
    do_beat();
    check("ovr_ready", bus.height_ready_out, 1);
    do_beat();
    check("ovr_err", bus.error_out, 1);
    check("ovr_code", bus.error_code_out, 3);
    do_stop();

    // Beat and handshake in the same cycle: handshake wins
    do_start(3'd2);
    tick(2);
    do_beat();
    bus.beat_in = 1'b1;
    bus.height_valid_in = 1'b1;
    bus.height_in = 4'd2;
    tick();
    bus.beat_in = 1'b0;
    bus.height_valid_in = 1'b0;
    check("same_no_err", bus.error_out, 0);
    check("same_busy", bus.busy_out, 1);
    check("same_ready_low", bus.height_ready_out, 0);
    tick();
    check("same_next_ball", bus.next_ball_out, 1);
    check("same_next_time", bus.next_time_out, 0);
    do_stop();

    // Asynchronous reset while waiting for a height
    do_start(3'd2);
    tick(2);
    do_beat();
    #2 rst = 1'b1;
    #1;
    check("arst_ready", bus.height_ready_out, 0);
    check("arst_busy", bus.busy_out, 0);
    check("arst_throw", bus.throw_valid_out, 0);
    check("arst_next_ball", bus.next_ball_out, 0);
    tick();
    rst = 1'b0;
    tick();
    do_start(3'd0);
    check("zero_start_busy", bus.busy_out, 0);
    tick(2);
    check("zero_start_busy2", bus.busy_out, 0);
    check("zero_start_next_time", bus.next_time_out, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
